// File: rtl/instr_tx.sv
// ---------------------------------------------------------------------------
// instr_tx -- UART transmitter for 16-bit instruction words.
//
// Sends one instruction as two 8N1 frames, low byte first, then high byte.
// This is the transmit-side partner of the instruction receiver.
// Only one instruction can be in flight; a strobe while busy is dropped.
//
// Build option:
//   INSTR_TX_GAP_EN  when defined, the line idles high for GAP_BITS bit
//                    periods between the two bytes.
//
// Parameters:
//   CLKS_PER_BIT  clocks per UART bit (>= 2)
//   GAP_BITS      idle bit periods between the bytes (gap build only)
//
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-high reset
//   i_tx_dv      one-cycle send strobe, accepted only when idle
//   i_tx_instr   instruction word, sampled on the accepting edge
//   o_tx_serial  UART line, idles high
//   o_tx_active  high while a transfer is in progress
//   o_tx_done    one-cycle pulse after the high byte's stop bit
// ---------------------------------------------------------------------------
module instr_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int GAP_BITS     = 10
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tx_dv,
    input  logic [15:0] i_tx_instr,
    output logic        o_tx_serial,
    output logic        o_tx_active,
    output logic        o_tx_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef INSTR_TX_GAP_EN
    localparam int GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CLKS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, GAP, CLEANUP
    } state_t;

    logic [GW-1:0] gap_cnt_reg, gap_cnt_next;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, CLEANUP
    } state_t;

    // GAP_BITS only shapes the gap build; this empty block keeps the
    // parameter referenced so both builds share one parameter list.
    if (GAP_BITS < 0) begin : g_gap_bits_unused
    end
`endif

    state_t        state_reg, state_next;
    logic [CW-1:0] clk_cnt_reg, clk_cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic          byte_sel_reg, byte_sel_next;
    logic [15:0]   data_reg, data_next;
    logic          serial_reg, serial_next;
    logic          active_reg, active_next;
    logic          done_reg, done_next;
    logic [7:0]    cur_byte;

    assign cur_byte    = byte_sel_reg ? data_reg[15:8] : data_reg[7:0];
    assign o_tx_serial = serial_reg;
    assign o_tx_active = active_reg;
    assign o_tx_done   = done_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg    <= IDLE;
            clk_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            byte_sel_reg <= 1'b0;
            data_reg     <= '0;
            serial_reg   <= 1'b1;
            active_reg   <= 1'b0;
            done_reg     <= 1'b0;
`ifdef INSTR_TX_GAP_EN
            gap_cnt_reg  <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            clk_cnt_reg  <= clk_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            byte_sel_reg <= byte_sel_next;
            data_reg     <= data_next;
            serial_reg   <= serial_next;
            active_reg   <= active_next;
            done_reg     <= done_next;
`ifdef INSTR_TX_GAP_EN
            gap_cnt_reg  <= gap_cnt_next;
`endif
        end
    end

    // Outputs are computed as next values and registered, so the line level
    // seen during a state is set on the first edge spent in that state.
    always_comb begin
        state_next    = state_reg;
        clk_cnt_next  = clk_cnt_reg;
        bit_idx_next  = bit_idx_reg;
        byte_sel_next = byte_sel_reg;
        data_next     = data_reg;
        serial_next   = serial_reg;
        active_next   = active_reg;
        done_next     = 1'b0;
`ifdef INSTR_TX_GAP_EN
        gap_cnt_next  = gap_cnt_reg;
`endif

        case (state_reg)
            IDLE: begin
                serial_next  = 1'b1;
                clk_cnt_next = '0;
                bit_idx_next = '0;
                if (i_tx_dv) begin
                    data_next     = i_tx_instr;
                    byte_sel_next = 1'b0;
                    active_next   = 1'b1;
                    state_next    = START;
                end
            end

            START: begin
                serial_next = 1'b0;
                if (clk_cnt_reg == CLK_LAST) begin
                    clk_cnt_next = '0;
                    state_next   = DATA;
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

            DATA: begin
                serial_next = cur_byte[bit_idx_reg];
                if (clk_cnt_reg == CLK_LAST) begin
                    clk_cnt_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

            STOP: begin
                serial_next = 1'b1;
                if (clk_cnt_reg == CLK_LAST) begin
                    clk_cnt_next = '0;
                    if (byte_sel_reg) begin
                        state_next = CLEANUP;
                    end else begin
`ifdef INSTR_TX_GAP_EN
                        gap_cnt_next = '0;
                        state_next   = GAP;
`else
                        byte_sel_next = 1'b1;
                        state_next    = START;
`endif
                    end
                end else begin
                    clk_cnt_next = clk_cnt_reg + 1'b1;
                end
            end

`ifdef INSTR_TX_GAP_EN
            GAP: begin
                serial_next = 1'b1;
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_next  = '0;
                    byte_sel_next = 1'b1;
                    state_next    = START;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
`endif

            CLEANUP: begin
                serial_next = 1'b1;
                done_next   = 1'b1;
                active_next = 1'b0;
                state_next  = IDLE;
            end

            default: begin
                serial_next = 1'b1;
                active_next = 1'b0;
                state_next  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_tx.sv
// ---------------------------------------------------------------------------
// tb_instr_tx -- directed self-checking bench for instr_tx.
//
// Drives single instructions, a strobe during a transfer, an asynchronous
// reset in the high byte, and a back-to-back send on the done cycle.  The
// line is sampled mid-bit and reassembled into a word; honours
// INSTR_TX_GAP_EN for the gap build.
// ---------------------------------------------------------------------------
module tb_instr_tx;

    localparam int CPB  = 217;
    localparam int GAPB = 10;
`ifdef INSTR_TX_GAP_EN
    localparam int GAP_CLKS = GAPB * CPB;
`else
    localparam int GAP_CLKS = 0;
`endif
    // Edges from the accepting edge to the edge that raises o_tx_done.
    localparam int FRAME = 1 + 20 * CPB + GAP_CLKS;

    logic        i_clk;
    logic        i_rst;
    logic        i_tx_dv;
    logic [15:0] i_tx_instr;
    logic        o_tx_serial;
    logic        o_tx_active;
    logic        o_tx_done;

    int n_checks   = 0;
    int n_fail     = 0;
    int done_total = 0;

    instr_tx #(
        .CLKS_PER_BIT (CPB),
        .GAP_BITS     (GAPB)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_tx_dv     (i_tx_dv),
        .i_tx_instr  (i_tx_instr),
        .o_tx_serial (o_tx_serial),
        .o_tx_active (o_tx_active),
        .o_tx_done   (o_tx_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_tx_done === 1'b1) done_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called between edges; returns #1 after the accepting edge.
    task automatic start_tx(input logic [15:0] w);
        i_tx_dv    = 1'b1;
        i_tx_instr = w;
        @(posedge i_clk);
        #1;
        i_tx_dv    = 1'b0;
        i_tx_instr = 16'($urandom);
        chk("accept_active", o_tx_active, 1);
        chk("accept_line_high", o_tx_serial, 1);
    endtask

    // Follows one transfer from the accepting edge to the done edge.
    // inject_at != 0 raises a 16'hFFFF strobe for one cycle at that edge.
    task automatic check_frame(input logic [15:0] w, input int inject_at);
        logic [19:0] bits;
        logic [15:0] rx;
        int dn;
        int t;
        int k;
        bits = {1'b1, w[15:8], 1'b0, 1'b1, w[7:0], 1'b0};
        rx   = '0;
        dn   = 0;
        for (int e = 1; e <= FRAME; e++) begin
            @(posedge i_clk);
            #1;
            if (inject_at != 0) begin
                if (e == inject_at) begin
                    i_tx_dv    = 1'b1;
                    i_tx_instr = 16'hFFFF;
                end else begin
                    i_tx_dv = 1'b0;
                end
            end
            if (o_tx_done === 1'b1 && e != FRAME) dn++;
            t = e - 1;
            if (e == 1) chk("start_edge", o_tx_serial, 0);
            if (t == 9 * CPB - 1) chk("lo_bit7_end", o_tx_serial, bits[8]);
            if (t == 9 * CPB) chk("lo_stop_begin", o_tx_serial, 1);
            if (t == 10 * CPB + GAP_CLKS - 1) chk("hi_pre_start", o_tx_serial, 1);
            if (t == 10 * CPB + GAP_CLKS) chk("hi_start_begin", o_tx_serial, 0);
            k = -1;
            if (t < 10 * CPB) k = t / CPB;
            else if (t >= 10 * CPB + GAP_CLKS) k = 10 + (t - 10 * CPB - GAP_CLKS) / CPB;
            else if (((t - 10 * CPB) % CPB) == CPB / 2) chk("gap_high", o_tx_serial, 1);
            if (k >= 0 && (t % CPB) == CPB / 2) begin
                chk($sformatf("bit%0d_w%04h", k, w), o_tx_serial, bits[k]);
                chk("active_mid", o_tx_active, 1);
                if (k >= 1 && k <= 8) rx[k - 1] = o_tx_serial;
                if (k >= 11 && k <= 18) rx[k - 3] = o_tx_serial;
            end
            if (e == FRAME - 1) chk("done_not_early", o_tx_done, 0);
        end
        chk("done_pulse", o_tx_done, 1);
        chk("active_end", o_tx_active, 0);
        chk("line_end", o_tx_serial, 1);
        chk("no_extra_done", dn, 0);
        chk($sformatf("rx_word_%04h", w), rx, w);
    endtask

    initial begin
        i_rst      = 1'b1;
        i_tx_dv    = 1'b0;
        i_tx_instr = '0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_serial", o_tx_serial, 1);
        chk("rst_active", o_tx_active, 0);
        chk("rst_done", o_tx_done, 0);
        i_rst = 1'b0;

        // Idle after reset: line high, nothing active, no done.
        for (int i = 0; i < 100; i++) begin
            @(posedge i_clk);
            #1;
            chk("idle", {o_tx_serial, o_tx_active, o_tx_done}, 3'b100);
        end

        // Plain transfer; reassembled word must be the hand value.
        start_tx(16'hAB37);
        check_frame(16'hAB37, 0);
        chk("loop_AB37", {o_tx_active, o_tx_serial}, 2'b01);

        repeat (5) @(posedge i_clk);
        #1;

        // Second strobe in the low byte's DATA bits is dropped.
        start_tx(16'h1234);
        check_frame(16'h1234, 3 * CPB + 10);
        repeat (5) @(posedge i_clk);
        #1;
        chk("no_requeue", {o_tx_serial, o_tx_active}, 2'b10);

        // Asynchronous reset during the high byte's DATA bits.
        start_tx(16'hC3A5);
        repeat (12 * CPB + GAP_CLKS + 20) @(posedge i_clk);
        #1;
        chk("pre_rst_active", o_tx_active, 1);
        i_rst = 1'b1;
        #1;
        chk("rst_mid_serial", o_tx_serial, 1);
        chk("rst_mid_active", o_tx_active, 0);
        chk("rst_mid_done", o_tx_done, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        start_tx(16'h00FF);
        check_frame(16'h00FF, 0);

        repeat (5) @(posedge i_clk);
        #1;

        // Back-to-back: new strobe in the cycle o_tx_done is high.
        start_tx(16'h0F1E);
        check_frame(16'h0F1E, 0);
        start_tx(16'h5A5A);
        check_frame(16'h5A5A, 0);

        repeat (5) @(posedge i_clk);
        #1;
        chk("done_total", done_total, 5);
        chk("final_idle", {o_tx_serial, o_tx_active, o_tx_done}, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
